serial_subtractor: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 24 ++
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the counter-width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake, operands and results of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf
    );
endinterface

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell: d = a - b - bin, borrow out in bout.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB first over WIDTH
// clocks, with a borrow flip-flop and held result registers.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = clog2(WIDTH);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-2:0] diff_sh_r;
    logic             brw_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic             cell_d_s;
    logic             cell_bout_s;

    full_subtractor u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (brw_r),
        .d    (cell_d_s),
        .bout (cell_bout_s)
    );

    // Next-state decode; a start is honoured from both IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                last_s = (cnt_r == CW'(WIDTH - 1));
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and status flags, decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture and per-bit shifting through the single cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r    <= '0;
            b_sh_r    <= '0;
            diff_sh_r <= '0;
            brw_r     <= 1'b0;
            a_msb_r   <= 1'b0;
            b_msb_r   <= 1'b0;
            cnt_r     <= '0;
        end else if (accept_s) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            brw_r   <= bus.bin;
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
            cnt_r   <= '0;
        end else if (state_r == RUN) begin
            a_sh_r    <= a_sh_r >> 1;
            b_sh_r    <= b_sh_r >> 1;
            diff_sh_r <= (diff_sh_r >> 1) | ((WIDTH-1)'(cell_d_s) << (WIDTH - 2));
            brw_r     <= cell_bout_s;
            cnt_r     <= cnt_r + CW'(1);
        end
    end

    // Result registers load only on the last bit and hold through later runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r    <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_s) begin
            d_r    <= {cell_d_s, diff_sh_r};
            bout_r <= cell_bout_s;
            ovf_r  <= (a_msb_r != b_msb_r) & (cell_d_s != a_msb_r);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    int   test_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed-overflow reference from integer range, independent of sign-bit tricks.
    function automatic logic ref_ovf(input int w, input int a, input int b, input int bin);
        int half;
        int sa;
        int sb;
        int r;
        half = 1 << (w - 1);
        sa = (a >= half) ? a - (1 << w) : a;
        sb = (b >= half) ? b - (1 << w) : b;
        r  = sa - sb - bin;
        return (r < -half) || (r > half - 1);
    endfunction

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        int busy_n;
        bus8.a = a;
        bus8.b = b;
        bus8.bin = bin;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.bin = 1'($urandom);
        n = 0;
        busy_n = 0;
        while (bus8.done !== 1'b1 && n < 20) begin
            if (bus8.busy === 1'b1) busy_n++;
            tick();
            n++;
        end
        check_eq({tag, "/latency"}, n, 8);
        check_eq({tag, "/busy_cycles"}, busy_n, 8);
        check_eq({tag, "/busy_in_done"}, bus8.busy, 1'b0);
        check_eq({tag, "/d"}, bus8.d, ed);
        check_eq({tag, "/bout"}, bus8.bout, eb);
        check_eq({tag, "/ovf"}, bus8.ovf, eo);
        tick();
        check_eq({tag, "/done_pulse"}, bus8.done, 1'b0);
        check_eq({tag, "/d_held"}, bus8.d, ed);
    endtask

    task automatic op4(input int a, input int b, input int bin);
        int n;
        logic [4:0] exp5;
        bus4.a = 4'(a);
        bus4.b = 4'(b);
        bus4.bin = 1'(bin);
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        n = 0;
        while (bus4.done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        exp5 = 5'(a - b - bin);
        check_eq($sformatf("w4 %0d-%0d-%0d/latency", a, b, bin), n, 4);
        check_eq($sformatf("w4 %0d-%0d-%0d/bout_d", a, b, bin), {bus4.bout, bus4.d}, exp5);
        check_eq($sformatf("w4 %0d-%0d-%0d/ovf", a, b, bin), bus4.ovf, ref_ovf(4, a, b, bin));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ha;
        logic [7:0] hb;
        logic       hbin;
        logic [8:0] exp9;
        logic [7:0] last_d;
        int         done_n;

        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.bin = 1'b0;
        ha = 8'h00; hb = 8'h00; hbin = 1'b0; last_d = 8'h00;
        #1;
        check_eq("reset/d", bus8.d, 8'h00);
        check_eq("reset/bout", bus8.bout, 1'b0);
        check_eq("reset/ovf", bus8.ovf, 1'b0);
        check_eq("reset/busy", bus8.busy, 1'b0);
        check_eq("reset/done", bus8.done, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        op8("5a-23",    8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        op8("00-01",    8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op8("80-01",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8("10-0f-1",  8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        op8("7f-ff",    8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // start held high: accepts land at k = 0, 9, 18; done follows 8 edges later
        for (int k = 0; k < 27; k++) begin
            bus8.a = 8'(k * 37 + 5);
            bus8.b = 8'(k * 91 + 200);
            bus8.bin = 1'(k % 2);
            bus8.start = 1'b1;
            if (k % 9 == 0) begin
                ha = bus8.a; hb = bus8.b; hbin = bus8.bin;
            end
            tick();
            if (k % 9 == 8) begin
                exp9 = 9'(int'(ha) - int'(hb) - int'(hbin));
                check_eq("hold/done", bus8.done, 1'b1);
                check_eq("hold/d", bus8.d, exp9[7:0]);
                check_eq("hold/bout", bus8.bout, exp9[8]);
                check_eq("hold/ovf", bus8.ovf, ref_ovf(8, int'(ha), int'(hb), int'(hbin)));
                last_d = exp9[7:0];
            end else begin
                check_eq("hold/no_done", bus8.done, 1'b0);
                if (k >= 9) check_eq("hold/d_stable", bus8.d, last_d);
            end
        end
        bus8.start = 1'b0;
        tick();

        // reset in the middle of a run aborts it with no done pulse
        bus8.a = 8'h5A; bus8.b = 8'h23; bus8.bin = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (4) tick();
        check_eq("rst/busy_before", bus8.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst/d", bus8.d, 8'h00);
        check_eq("rst/bout", bus8.bout, 1'b0);
        check_eq("rst/ovf", bus8.ovf, 1'b0);
        check_eq("rst/busy", bus8.busy, 1'b0);
        check_eq("rst/done", bus8.done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done === 1'b1) done_n++;
        end
        check_eq("rst/no_done_pulse", done_n, 0);
        op8("after_rst", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op4(a, b, c);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
